// File: rtl/sdiv60x32_iter.sv
// Iterative signed divider: 60-bit dividend / 32-bit divisor -> saturated 28-bit quotient plus exact 32-bit remainder.
// Latency: done pulses DW+1 edges after the start edge; one result per DW+2 cycles.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped. Optional SDIV_ROUND_EN rounds half away from zero.
module sdiv60x32_iter #(
  parameter int DW = 60,
  parameter int VW = 32,
  parameter int QW = 28
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic [QW-1:0] q,
  output logic [VW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          dz
);

  localparam int CW  = $clog2(DW + 1);
  localparam int DW1 = DW + 1;

  // Saturation limits on the unsigned quotient magnitude.
  localparam logic [DW:0]   QPOS_LIM = DW1'((64'd1 << (QW - 1)) - 64'd1);
  localparam logic [DW:0]   QNEG_LIM = DW1'(64'd1 << (QW - 1));
  localparam logic [QW-1:0] Q_MAX    = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN    = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_q;   // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0] rem_q;   // partial remainder, always < |b| so VW bits suffice
  logic [VW-1:0] bmag_q;
  logic          sa_q;
  logic          sb_q;
  logic          bz_q;

  // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  assign a_mag = a[DW-1] ? (~a + DW'(1)) : a;
  assign b_mag = b[VW-1] ? (~b + VW'(1)) : b;

  // One restoring step: the shifted partial remainder needs VW+1 bits for the compare.
  logic [VW:0]   shifted;
  logic          ge;
  logic [VW-1:0] diff;
  logic [VW-1:0] rem_nxt;
  logic [DW-1:0] dvd_nxt;
  assign shifted = {rem_q, dvd_q[DW-1]};
  assign ge      = shifted >= {1'b0, bmag_q};
  assign diff    = shifted[VW-1:0] - bmag_q;
  assign rem_nxt = ge ? diff : shifted[VW-1:0];
  assign dvd_nxt = {dvd_q[DW-2:0], ge};

  logic [DW:0]   qmag;
  logic          neg;
  logic          sat_hi;
  logic          sat_lo;
  logic [QW-1:0] q_trunc;
  logic [QW-1:0] q_fin;
  logic [VW-1:0] r_fin;

  // Final sign correction, optional rounding and saturation of the quotient.
  always_comb begin
    qmag = {1'b0, dvd_q};
`ifdef SDIV_ROUND_EN
    // Round half away from zero on the magnitude; r keeps the truncating remainder.
    if ({rem_q, 1'b0} >= {1'b0, bmag_q})
      qmag = qmag + DW1'(1);
`endif
    neg     = sa_q ^ sb_q;
    sat_hi  = !neg && (qmag > QPOS_LIM);
    sat_lo  = neg && (qmag > QNEG_LIM);
    q_trunc = qmag[QW-1:0];
    if (sat_hi)
      q_fin = Q_MAX;
    else if (sat_lo)
      q_fin = Q_MIN;
    else if (neg)
      q_fin = ~q_trunc + QW'(1);
    else
      q_fin = q_trunc;
    // Remainder follows the dividend's sign; magnitude is below 2^(VW-1) so it never overflows.
    r_fin = sa_q ? (~rem_q + VW'(1)) : rem_q;
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      bmag_q <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      q      <= '0;
      r      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_q  <= a_mag;
            rem_q  <= '0;
            bmag_q <= b_mag;
            sa_q   <= a[DW-1];
            sb_q   <= b[VW-1];
            bz_q   <= (b == '0);
            cnt    <= CW'(DW);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIN;
        end
        FIN: begin
          if (bz_q) begin
            // Divide by zero saturates toward the dividend's sign.
            q   <= sa_q ? Q_MIN : Q_MAX;
            r   <= '0;
            ovf <= 1'b0;
            dz  <= 1'b1;
          end else begin
            q   <= q_fin;
            r   <= r_fin;
            ovf <= sat_hi | sat_lo;
            dz  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv60x32_iter.sv
// Directed bench for sdiv60x32_iter: latency, busy window, signs, saturation, divide by zero.
// Also covers ignored start while busy and asynchronous reset mid-operation.
// Inputs driven and outputs sampled on the falling edge of pclk.
module tb_sdiv60x32_iter;

  localparam int DW = 60;
  localparam int VW = 32;
  localparam int QW = 28;
`ifdef SDIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam logic [QW-1:0] QMAX = 28'h7FFFFFF;
  localparam logic [QW-1:0] QMIN = 28'h8000000;

  logic          pclk;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic [QW-1:0] q;
  logic [VW-1:0] r;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          dz;

  int npass = 0;
  int nchk  = 0;

  sdiv60x32_iter #(.DW(DW), .VW(VW), .QW(QW)) dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .q       (q),
    .r       (r),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .dz      (dz)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; issues one request and checks latency, busy window and results.
  task automatic run_op(input string tag, input logic [DW-1:0] ta, input logic [VW-1:0] tb_v,
                        input logic [QW-1:0] eq, input logic [VW-1:0] er,
                        input logic eovf, input logic edz, input int inj);
    int k;
    int got;
    int busy_err;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start = 1'b0;
    a = '0;
    b = '0;
    k = 0;
    got = -1;
    busy_err = 0;
    while (k <= 200 && got < 0) begin
      if (done) begin
        got = k;
        if (busy) busy_err++;
      end else begin
        if (!busy) busy_err++;
        if (inj > 0 && k == inj - 1) begin
          start = 1'b1;
          a = 60'd5;
          b = 32'd1;
        end else if (inj > 0 && k == inj) begin
          start = 1'b0;
        end
        @(posedge pclk);
        @(negedge pclk);
        k++;
      end
    end
    chk({tag, " latency"}, 64'(got), 64'(DW + 1));
    chk({tag, " busy"}, 64'(busy_err), 64'd0);
    chk({tag, " q"}, 64'(q), 64'(eq));
    chk({tag, " r"}, 64'(r), 64'(er));
    chk({tag, " ovf"}, 64'(ovf), 64'(eovf));
    chk({tag, " dz"}, 64'(dz), 64'(edz));
  endtask

  initial begin
    int extra;
    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(negedge pclk);
    chk("rst q", 64'(q), 64'd0);
    chk("rst r", 64'(r), 64'd0);
    chk("rst flags", 64'({busy, done, ovf, dz}), 64'd0);
    reset_n = 1'b1;
    @(negedge pclk);

    run_op("p/p", 60'd1000, 32'd7, RND ? 28'd143 : 28'd142, 32'd6, 1'b0, 1'b0, 0);
    run_op("n/p", 60'(-1000), 32'd7, RND ? 28'(-143) : 28'(-142), 32'(-6), 1'b0, 1'b0, 0);
    run_op("p/n", 60'd1000, 32'(-7), RND ? 28'(-143) : 28'(-142), 32'd6, 1'b0, 1'b0, 0);
    run_op("sat+", 60'h10000000000, 32'd3, QMAX, 32'd1, 1'b1, 1'b0, 0);
    run_op("minneg", 60'h800000000000000, 32'(-1), QMAX, 32'd0, 1'b1, 1'b0, 0);
    run_op("dz neg", 60'(-5), 32'd0, QMIN, 32'd0, 1'b0, 1'b1, 0);
    run_op("dz pos", 60'd5, 32'd0, QMAX, 32'd0, 1'b0, 1'b1, 0);
    run_op("9/3", 60'd9, 32'd3, 28'd3, 32'd0, 1'b0, 1'b0, 0);
    run_op("zero", 60'd0, 32'd5, 28'd0, 32'd0, 1'b0, 1'b0, 0);

    // A second start at E0+10 must be dropped: same result, one done only.
    run_op("busy start", 60'd1000, 32'(-7), RND ? 28'(-143) : 28'(-142), 32'd6, 1'b0, 1'b0, 10);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (done) extra++;
    end
    chk("busy start extra done", 64'(extra), 64'd0);

    // Reset in the middle of a computation aborts with no done.
    a = 60'd1000;
    b = 32'd7;
    start = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start = 1'b0;
    repeat (29) @(posedge pclk);
    @(posedge pclk);
    #1 reset_n = 1'b0;
    @(negedge pclk);
    chk("abort q", 64'(q), 64'd0);
    chk("abort r", 64'(r), 64'd0);
    chk("abort flags", 64'({busy, done, ovf, dz}), 64'd0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      if (done) extra++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge pclk);
      if (done) extra++;
    end
    chk("abort no done", 64'(extra), 64'd0);

    run_op("after rst", 60'(-7), 32'd2, RND ? 28'(-4) : 28'(-3), 32'(-1), 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
